// File: rtl/alu_64_bit_slim_withbr.sv
// RV64I execute-stage ALU: arithmetic, logic, shift, compare and branch-condition ops with a one-cycle registered result.
// Build option: define ALU_CMP_FLAGS_EN to add registered compare flag outputs (out_slt, out_sltu, out_grt, out_grtu).
module alu_64_bit_slim_withbr #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7,
  output logic [XLEN-1:0] out_rd
`ifdef ALU_CMP_FLAGS_EN
  ,
  output logic            out_slt,
  output logic            out_sltu,
  output logic            out_grt,
  output logic            out_grtu
`endif
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SLL  = 4'h1, OP_SLT  = 4'h2, OP_SLTU = 4'h3,
    OP_XOR  = 4'h4, OP_SRL  = 4'h5, OP_OR   = 4'h6, OP_AND  = 4'h7,
    OP_SUB  = 4'h8, OP_BEQ  = 4'h9, OP_BNE  = 4'hA, OP_BLT  = 4'hB,
    OP_BGE  = 4'hC, OP_SRA  = 4'hD, OP_BLTU = 4'hE, OP_BGEU = 4'hF
  } op_e;

  op_e             w_op;
  logic [5:0]      w_shamt;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic [XLEN-1:0] w_result;

  assign w_op    = op_e'({in_funct7, in_funct3});
  assign w_shamt = in_rs2[5:0];
  assign w_eq    = (in_rs1 == in_rs2);
  // Direct signed comparison stays correct at the overflow extremes, unlike the sign of rs1-rs2.
  assign w_lt_s  = ($signed(in_rs1) < $signed(in_rs2));
  assign w_lt_u  = (in_rs1 < in_rs2);

  // NOTE: w_result gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_result = '0;
    unique case (w_op)
      OP_ADD:  w_result = in_rs1 + in_rs2;
      OP_SUB:  w_result = in_rs1 - in_rs2;
      OP_SLL:  w_result = in_rs1 << w_shamt;
      OP_SRL:  w_result = in_rs1 >> w_shamt;
      OP_SRA:  w_result = $signed(in_rs1) >>> w_shamt;
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_s};
      OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_u};
      OP_XOR:  w_result = in_rs1 ^ in_rs2;
      OP_OR:   w_result = in_rs1 | in_rs2;
      OP_AND:  w_result = in_rs1 & in_rs2;
      OP_BEQ:  w_result = {{(XLEN-1){1'b0}}, w_eq};
      OP_BNE:  w_result = {{(XLEN-1){1'b0}}, ~w_eq};
      OP_BLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_s};
      OP_BGE:  w_result = {{(XLEN-1){1'b0}}, ~w_lt_s};
      OP_BLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_u};
      OP_BGEU: w_result = {{(XLEN-1){1'b0}}, ~w_lt_u};
      default: w_result = '0;
    endcase
  end

  logic [XLEN-1:0] r_rd;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_rd <= '0;
    else     r_rd <= w_result;
  end

  assign out_rd = r_rd;

`ifdef ALU_CMP_FLAGS_EN
  logic r_slt, r_sltu, r_grt, r_grtu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slt  <= 1'b0;
      r_sltu <= 1'b0;
      r_grt  <= 1'b0;
      r_grtu <= 1'b0;
    end else begin
      r_slt  <= w_lt_s;
      r_sltu <= w_lt_u;
      r_grt  <= ~w_lt_s & ~w_eq;
      r_grtu <= ~w_lt_u & ~w_eq;
    end
  end

  assign out_slt  = r_slt;
  assign out_sltu = r_sltu;
  assign out_grt  = r_grt;
  assign out_grtu = r_grtu;
`endif

endmodule

// File: tb/tb_alu_64_bit_slim_withbr.sv
// Directed self-checking bench for alu_64_bit_slim_withbr with hand-computed expected results.
module tb_alu_64_bit_slim_withbr;

  logic        clk;
  logic        rst;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7;
  logic [63:0] out_rd;
`ifdef ALU_CMP_FLAGS_EN
  logic out_slt, out_sltu, out_grt, out_grtu;
`endif

  int checks   = 0;
  int failures = 0;

  alu_64_bit_slim_withbr dut (
    .clk       (clk),
    .rst       (rst),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .out_rd    (out_rd)
`ifdef ALU_CMP_FLAGS_EN
    ,
    .out_slt   (out_slt),
    .out_sltu  (out_sltu),
    .out_grt   (out_grt),
    .out_grtu  (out_grtu)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one op, let the next rising edge capture it, then sample 1 time unit after.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    in_funct7 = op[3];
    in_funct3 = op[2:0];
    in_rs1    = a;
    in_rs2    = b;
    @(posedge clk);
    #1;
    check(tag, out_rd, exp);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    rst = 1'b1;
    in_rs1 = 64'd1; in_rs2 = 64'd2; in_funct3 = 3'h0; in_funct7 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", out_rd, 64'd0);
    rst = 1'b0;

    run_op("add_1_2",   4'h0, 64'd1, 64'd2, 64'd3);
    run_op("sub_1_2",   4'h8, 64'd1, 64'd2, ONES);
    run_op("sub_6_2",   4'h8, 64'd6, 64'd2, 64'd4);
    run_op("add_wrap",  4'h0, ONES, 64'd1, 64'd0);

    run_op("srl_6_2",   4'h5, 64'd6, 64'd2, 64'd1);
    run_op("sra_6_2",   4'hD, 64'd6, 64'd2, 64'd1);
    run_op("sra_neg",   4'hD, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC);
    run_op("srl_neg",   4'h5, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'h3FFF_FFFF_FFFF_FFFC);
    run_op("sll_mask",  4'h1, 64'd1, 64'h43, 64'd8);
    run_op("sll_63",    4'h1, 64'd1, 64'd63, SMIN);
    run_op("sra_63",    4'hD, SMIN, 64'd63, ONES);
    run_op("srl_63",    4'h5, SMIN, 64'd63, 64'd1);
    run_op("sll_zero",  4'h1, 64'h1234_5678_9ABC_DEF0, 64'h40, 64'h1234_5678_9ABC_DEF0);

    run_op("xor",       4'h4, 64'hF0F0, 64'hFF00, 64'h0FF0);
    run_op("or",        4'h6, 64'hF0F0, 64'hFF00, 64'hFFF0);
    run_op("and",       4'h7, 64'hF0F0, 64'hFF00, 64'hF000);

    run_op("slt_3_2",   4'h2, 64'd3, 64'd2, 64'd0);
    run_op("sltu_3_2",  4'h3, 64'd3, 64'd2, 64'd0);
    run_op("slt_3_4",   4'h2, 64'd3, 64'd4, 64'd1);
    run_op("sltu_3_4",  4'h3, 64'd3, 64'd4, 64'd1);
    run_op("slt_n13_2", 4'h2, 64'hFFFF_FFFF_FFFF_FFF3, 64'd2, 64'd1);
    run_op("sltu_n13_2",4'h3, 64'hFFFF_FFFF_FFFF_FFF3, 64'd2, 64'd0);
    run_op("slt_2_n13", 4'h2, 64'd2, 64'hFFFF_FFFF_FFFF_FFF3, 64'd0);
    run_op("sltu_2_n13",4'h3, 64'd2, 64'hFFFF_FFFF_FFFF_FFF3, 64'd1);
    run_op("slt_m1_m2", 4'h2, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    run_op("sltu_m1_m2",4'h3, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    run_op("slt_eq",    4'h2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    run_op("sltu_eq",   4'h3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);

    run_op("beq_eq",    4'h9, 64'd2, 64'd2, 64'd1);
    run_op("beq_ne",    4'h9, 64'd3, 64'd2, 64'd0);
    run_op("bne_eq",    4'hA, 64'd2, 64'd2, 64'd0);
    run_op("bne_ne",    4'hA, 64'd3, 64'd2, 64'd1);
    run_op("blt_t",     4'hB, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFF3, 64'd1);
    run_op("blt_nt",    4'hB, 64'hFFFF_FFFF_FFFF_FFF3, 64'hFFFF_FFFF_FFFF_FFF2, 64'd0);
    run_op("bltu_nt",   4'hE, 64'hFFFF_FFFF_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFF3, 64'd0);
    run_op("bltu_t",    4'hE, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd1);
    run_op("bge_eq",    4'hC, 64'd7, 64'd7, 64'd1);
    run_op("bgeu_eq",   4'hF, 64'd7, 64'd7, 64'd1);
    run_op("bge_m1_0",  4'hC, ONES, 64'd0, 64'd0);
    run_op("bgeu_m1_0", 4'hF, ONES, 64'd0, 64'd1);
    run_op("blt_eq",    4'hB, 64'd7, 64'd7, 64'd0);
    run_op("bltu_eq",   4'hE, 64'd7, 64'd7, 64'd0);

    run_op("slt_ovf",   4'h2, SMIN, SMAX, 64'd1);
    run_op("sltu_ovf",  4'h3, SMIN, SMAX, 64'd0);
`ifdef ALU_CMP_FLAGS_EN
    check("flag_slt",  {63'd0, out_slt},  64'd1);
    check("flag_sltu", {63'd0, out_sltu}, 64'd0);
    check("flag_grt",  {63'd0, out_grt},  64'd0);
    check("flag_grtu", {63'd0, out_grtu}, 64'd1);
`endif
    run_op("bgeu_ovf",  4'hF, SMIN, SMAX, 64'd1);
    run_op("bge_ovf",   4'hC, SMIN, SMAX, 64'd0);

    // Reset mid-stream must win over a live op that would otherwise produce a nonzero result.
    rst = 1'b1;
    run_op("reset_mid", 4'h6, ONES, ONES, 64'd0);
`ifdef ALU_CMP_FLAGS_EN
    check("flag_rst",  {60'd0, out_slt, out_sltu, out_grt, out_grtu}, 64'd0);
`endif
    rst = 1'b0;
    run_op("after_rst", 4'h0, 64'd10, 64'd5, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
